sccb_arbiter: RTL and testbench
===============================

# sccb_arbiter

Round-robin arbiter that shares one SCCB master (`sccb_*` ports) between `NUM_REQ` requesters. Typical requesters are the boot-time sensor configuration sequencer and a run-time register writer for exposure or white balance. Each requester port mirrors the SCCB master's own start/ready handshake, so a requester written for a dedicated SCCB master works unchanged. The arbiter owns the SCCB master for a whole write: it issues start, waits for busy, then waits for completion. A watchdog frees the bus if the SCCB master stalls.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..4.
- `TIMEOUT_CYCLES`, default 1_000_000: watchdog limit, counted per transaction; 40 ms at 25 MHz.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_start`  in  NUM_REQ  per-requester transfer request, level.
- `req_addr`  in  8*NUM_REQ  register address; requester i uses bits [8i+7:8i].
- `req_data`  in  8*NUM_REQ  register data, same packing as `req_addr`.
- `req_ready`  out  NUM_REQ  per-requester ready; 1 = arbiter can accept.
- `req_done`  out  NUM_REQ  one-cycle pulse to the granted requester at end of its transaction.
- `req_err`  out  NUM_REQ  one-cycle pulse, coincident with `req_done`, when that transaction timed out.
- `sccb_ready`  in  1  SCCB master ready; 0 = busy.
- `sccb_start`  out  1  start to SCCB master, registered.
- `sccb_addr`  out  8  address to SCCB master, registered.
- `sccb_data`  out  8  data to SCCB master, registered.
- `grant`  out  2  index of the current or last granted requester.
- `busy`  out  1  1 whenever state is not IDLE.
- `timeout_flag`  out  1  sticky; set on any timeout, cleared only by `rst`.

## Operation
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE
  - `req_ready[i] = sccb_ready` for all i (combinational). `sccb_start = 0`.
  - If `sccb_ready = 1` and any `req_start` bit is set, select the first set bit searching from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - On selection: latch that requester's addr/data into `sccb_addr`/`sccb_data`, set `grant`, clear `timer`, set `sccb_start = 1`, go to ISSUE.
- ISSUE
  - All `req_ready` = 0. `sccb_start` held at 1.
  - `sccb_ready = 0` observed: `sccb_start <= 0`, go to BUSY.
  - Else if `timer == TIMEOUT_CYCLES-1`: `sccb_start <= 0`, set the error condition, go to DONE.
  - Otherwise `timer` increments.
- BUSY
  - All `req_ready` = 0.
  - `sccb_ready = 1` observed: go to DONE.
  - Else if `timer == TIMEOUT_CYCLES-1`: set the error condition, go to DONE.
  - Otherwise `timer` increments. `timer` is not cleared between ISSUE and BUSY.
- DONE
  - One cycle. `req_done[grant] = 1`; `req_err[grant] = 1` if the error condition is set; `timeout_flag` is set on error.
  - `rr_ptr <= (grant+1) mod NUM_REQ`. Go to IDLE.
- `timer`: 24 bits, saturating; never wraps.
- `sccb_addr`/`sccb_data` stay stable from the IDLE→ISSUE edge until the next grant.
- A requester whose `req_start` is set while not granted sees `req_ready = 0` and simply waits. Its request is not lost, provided it holds `req_start`.

## Timing
- Reset values: state IDLE, `sccb_start` 0, `sccb_addr` 0, `sccb_data` 0, `req_done` 0, `req_err` 0, `grant` 0, `rr_ptr` 0, `timer` 0, `timeout_flag` 0, `busy` 0.
- `req_start` sampled at edge N in IDLE → `sccb_start` high from cycle N+1. `req_ready` goes low in cycle N+1.
- `sccb_ready` seen low at edge M → `sccb_start` low from M+1.
- `sccb_ready` seen high in BUSY at edge K → `req_done` pulse in cycle K+1 → IDLE (ready again) in cycle K+2.
- Minimum gap between consecutive grants: 2 cycles (DONE, then IDLE).
- Simultaneous requests: `rr_ptr` priority. Consecutive back-to-back requesters alternate; none is granted twice in a row while another is waiting.
- `sccb_ready = 0` while in IDLE: no grant. All `req_ready` = 0.
- `sccb_ready` high for the whole ISSUE timeout: error. Transaction is reported done with `req_err` set.
- `rst` mid-transaction: immediate return to IDLE and all outputs to reset values. The SCCB master handles its own abort.

## Test plan
- Single request: requester 0 asserts `req_start` with addr 0x12, data 0x80. Model SCCB busy 300 cycles. → `sccb_start` high 1 cycle after request; `sccb_addr` 0x12, `sccb_data` 0x80; `req_done[0]` pulse exactly once, 1 cycle after `sccb_ready` rises.
- Contention: requesters 0 and 1 assert in the same cycle, both holding start until their done. → Grant order 0, 1, 0, 1. `req_ready[1]` stays 0 throughout requester 0's transaction.
- Busy hold-off: requester 1 asserts while requester 0's transfer is in BUSY. → No second `sccb_start` until after `req_done[0]`. Requester 1 is granted on the first IDLE cycle.
- ISSUE timeout: `TIMEOUT_CYCLES = 16`, model never drops `sccb_ready`. → `req_done[0]` and `req_err[0]` pulse at cycle 17 after grant; `timeout_flag` = 1; `sccb_start` low.
- BUSY timeout: model drops `sccb_ready` and never raises it. → Same error response. The next request is then served normally, with `timer` restarting from 0.
- Reset mid-BUSY: assert `rst` asynchronously. → All outputs at reset values within the reset cycle. After release, `rr_ptr` is 0 and requester 0 wins a tie.

Source files
------------

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: round-robin sharing of one SCCB master between NUM_REQ requesters, with a per-transaction watchdog
module sccb_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_start,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    input  logic                   sccb_ready,
    output logic                   sccb_start,
    output logic [7:0]             sccb_addr,
    output logic [7:0]             sccb_data,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic                   timeout_flag
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
    localparam logic [23:0] T_LAST = 24'(TIMEOUT_CYCLES - 1);
    state_t state_q, state_d;
    logic start_q, start_d, err_q, err_d, timeout_flag_q, timeout_flag_d, hit;
    logic [7:0] addr_q, addr_d, data_q, data_d, sel_addr, sel_data;
    logic [1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, sel;
    logic [23:0] timer_q, timer_d, timer_inc;
    logic [NUM_REQ-1:0] one_hot;
    int best;
    // pick the pending requester closest to rr_ptr going upward, wrapping
    always_comb begin
        best = NUM_REQ;
        sel = rr_ptr_q;
        sel_addr = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_start[j] && ((j + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ) < best) begin
                best = (j + NUM_REQ - int'(rr_ptr_q)) % NUM_REQ;
                sel = 2'(j);
                sel_addr = req_addr[8*j +: 8];
                sel_data = req_data[8*j +: 8];
            end
        end
        hit = |req_start;
    end
    // transaction FSM: grant, hold start until the master goes busy, wait for completion, watchdog
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        addr_d = addr_q;
        data_d = data_q;
        grant_d = grant_q;
        rr_ptr_d = rr_ptr_q;
        err_d = err_q;
        timeout_flag_d = timeout_flag_q;
        timer_inc = (timer_q == '1) ? timer_q : timer_q + 24'd1;
        timer_d = timer_q;
        case (state_q)
            IDLE: if (sccb_ready && hit) begin
                addr_d = sel_addr;
                data_d = sel_data;
                grant_d = sel;
                timer_d = '0;
                err_d = 1'b0;
                start_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (!sccb_ready) begin
                start_d = 1'b0;
                state_d = BUSY;
            end else if (timer_q == T_LAST) begin
                start_d = 1'b0;
                err_d = 1'b1;
                state_d = DONE;
            end else timer_d = timer_inc;
            BUSY: if (sccb_ready) state_d = DONE;
            else if (timer_q == T_LAST) begin
                err_d = 1'b1;
                state_d = DONE;
            end else timer_d = timer_inc;
            default: begin
                rr_ptr_d = 2'((int'(grant_q) + 1) % NUM_REQ);
                timeout_flag_d = timeout_flag_q | err_q;
                state_d = IDLE;
            end
        endcase
    end
    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            grant_q <= '0;
            rr_ptr_q <= '0;
            timer_q <= '0;
            err_q <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            addr_q <= addr_d;
            data_q <= data_d;
            grant_q <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q <= timer_d;
            err_q <= err_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end
    assign one_hot = NUM_REQ'(1) << grant_q;
    assign req_ready = (state_q == IDLE) ? {NUM_REQ{sccb_ready}} : '0;
    assign req_done = (state_q == DONE) ? one_hot : '0;
    assign req_err = req_done & {NUM_REQ{err_q}};
    assign sccb_start = start_q;
    assign sccb_addr = addr_q;
    assign sccb_data = data_q;
    assign grant = grant_q;
    assign busy = state_q != IDLE;
    assign timeout_flag = timeout_flag_q;
endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: scoreboard bench for sccb_arbiter with a behavioural SCCB master model
module tb_sccb_arbiter;
    localparam int TO = 320;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req_start, req_ready, req_done, req_err, grant;
    logic [15:0] req_addr, req_data;
    logic sccb_ready, sccb_start, busy, timeout_flag;
    logic [7:0] sccb_addr, sccb_data;
    typedef struct {int idx; logic [7:0] addr; logic [7:0] data; logic err;} rec_t;
    rec_t exp_q[$], fly_q[$];
    int pend[2];
    logic [7:0] base_addr[2], base_data[2];
    int mode, busy_len, cnt, n_chk, n_pass, n_done;
    logic prev_start;

    sccb_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err), .sccb_ready(sccb_ready),
        .sccb_start(sccb_start), .sccb_addr(sccb_addr), .sccb_data(sccb_data), .grant(grant),
        .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_req
        assign req_start[g] = pend[g] != 0;
        assign req_addr[8*g +: 8] = base_addr[g] + 8'(pend[g]);
        assign req_data[8*g +: 8] = base_data[g] + 8'(pend[g]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input int p, input logic e);
        rec_t r;
        r.idx = i;
        r.addr = base_addr[i] + 8'(p);
        r.data = base_data[i] + 8'(p);
        r.err = e;
        exp_q.push_back(r);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int k = 0; k < budget && n_done < target; k++) tick;
        chk(tag, n_done, target);
    endtask

    // SCCB master model: mode 0 normal, 1 never goes busy, 2 goes busy and never finishes
    initial begin
        sccb_ready = 1'b1;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sccb_ready = 1'b1;
                cnt = 0;
            end else if (sccb_ready && sccb_start && mode != 1) begin
                sccb_ready = 1'b0;
                cnt = busy_len;
            end else if (!sccb_ready && mode == 0) begin
                if (cnt > 0) cnt--;
                if (cnt == 0) sccb_ready = 1'b1;
            end
        end
    end

    // scoreboard: pop expected grant on each start rise, then match its done/err pulse
    always @(posedge clk) begin
        rec_t r;
        #1;
        if (rst) begin
            fly_q.delete();
            prev_start = 1'b0;
        end else begin
            if (sccb_start && !prev_start) begin
                if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("sb_grant", grant, r.idx);
                    chk("sb_addr", sccb_addr, r.addr);
                    chk("sb_data", sccb_data, r.data);
                    fly_q.push_back(r);
                end
            end
            if (req_done != 0) begin
                n_done++;
                if (fly_q.size() == 0) chk("unexpected_done", req_done, 0);
                else begin
                    r = fly_q.pop_front();
                    chk("sb_done", req_done, 32'(1) << r.idx);
                    chk("sb_err", req_err, r.err ? 32'(1) << r.idx : 32'd0);
                    if (pend[r.idx] > 0) pend[r.idx]--;
                end
            end
            prev_start = sccb_start;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad, n;
        mode = 0;
        busy_len = 300;
        pend[0] = 0;
        pend[1] = 0;
        base_addr = '{8'h00, 8'h00};
        base_data = '{8'h00, 8'h00};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick;
        chk("rst_start", sccb_start, 0);
        chk("rst_addr", sccb_addr, 0);
        chk("rst_data", sccb_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", timeout_flag, 0);
        chk("rst_done", {req_done, req_err}, 0);
        chk("rst_ready", req_ready, 2'b11);

        base_addr[0] = 8'h11;
        base_data[0] = 8'h7F;
        push(0, 1, 1'b0);
        @(negedge clk);
        pend[0] = 1;
        tick;
        chk("single_start", sccb_start, 1);
        chk("single_ready_low", req_ready, 0);
        chk("single_busy", busy, 1);
        for (int k = 0; k < 5 && sccb_ready; k++) tick;
        for (int k = 0; k < 400 && !sccb_ready; k++) tick;
        chk("single_done_lat", req_done, 2'b01);
        tick;
        chk("single_done_once", req_done, 0);
        chk("single_idle_ready", req_ready, 2'b11);
        chk("single_ndone", n_done, 1);

        base_addr[0] = 8'h20;
        base_data[0] = 8'h90;
        base_addr[1] = 8'h3F;
        base_data[1] = 8'h4F;
        push(0, 1, 1'b0);
        push(1, 1, 1'b0);
        @(negedge clk);
        pend[0] = 1;
        for (int k = 0; k < 10 && !(busy && !sccb_start); k++) tick;
        pend[1] = 1;
        bad = 0;
        for (int k = 0; k < 400 && req_done == 0; k++) begin
            if (sccb_start || req_ready != 0) bad++;
            tick;
        end
        chk("holdoff_quiet", bad, 0);
        chk("holdoff_done0", req_done, 2'b01);
        tick;
        chk("holdoff_idle", busy, 0);
        tick;
        chk("holdoff_start1", sccb_start, 1);
        chk("holdoff_grant1", grant, 1);
        wait_done(3, 400, "holdoff_ndone");
        tick;

        busy_len = 20;
        base_addr = '{8'h20, 8'h30};
        base_data = '{8'hA0, 8'hB0};
        push(0, 2, 1'b0);
        push(1, 2, 1'b0);
        push(0, 1, 1'b0);
        push(1, 1, 1'b0);
        @(negedge clk);
        pend[0] = 2;
        pend[1] = 2;
        bad = 0;
        for (int k = 0; k < 600 && n_done < 7; k++) begin
            if (busy && req_ready != 0) bad++;
            tick;
        end
        chk("contend_ready", bad, 0);
        chk("contend_ndone", n_done, 7);
        chk("contend_queue", exp_q.size(), 0);
        tick;

        mode = 1;
        base_addr[0] = 8'h05;
        base_data[0] = 8'h06;
        push(0, 1, 1'b1);
        @(negedge clk);
        pend[0] = 1;
        tick;
        n = 0;
        while (n < TO + 10 && req_done == 0) begin
            tick;
            n++;
        end
        chk("issue_to_lat", n, TO);
        chk("issue_to_err", req_err, 2'b01);
        chk("issue_to_start", sccb_start, 0);
        tick;
        chk("issue_to_flag", timeout_flag, 1);

        mode = 2;
        base_addr[1] = 8'h60;
        base_data[1] = 8'h70;
        push(1, 1, 1'b1);
        @(negedge clk);
        pend[1] = 1;
        tick;
        n = 0;
        while (n < TO + 10 && req_done == 0) begin
            tick;
            n++;
        end
        chk("busy_to_lat", n, TO + 1);
        chk("busy_to_err", req_err, 2'b10);
        tick;
        chk("idle_noready", req_ready, 0);
        busy_len = 300;
        base_addr[0] = 8'h54;
        base_data[0] = 8'h65;
        push(0, 1, 1'b0);
        @(negedge clk);
        pend[0] = 1;
        repeat (3) tick;
        chk("idle_nogrant", {busy, sccb_start}, 0);
        mode = 0;
        wait_done(10, 500, "busy_to_recover");
        chk("flag_sticky", timeout_flag, 1);
        tick;

        base_addr[1] = 8'h10;
        base_data[1] = 8'h20;
        push(1, 1, 1'b0);
        @(negedge clk);
        pend[1] = 1;
        for (int k = 0; k < 10 && !(busy && !sccb_start); k++) tick;
        repeat (5) tick;
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_start", sccb_start, 0);
        chk("arst_addr", sccb_addr, 0);
        chk("arst_data", sccb_data, 0);
        chk("arst_grant", grant, 0);
        chk("arst_flag", timeout_flag, 0);
        chk("arst_done", {req_done, req_err}, 0);
        exp_q.delete();
        pend[0] = 0;
        pend[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy_len = 10;
        base_addr = '{8'h01, 8'h03};
        base_data = '{8'h02, 8'h04};
        push(0, 1, 1'b0);
        push(1, 1, 1'b0);
        pend[0] = 1;
        pend[1] = 1;
        tick;
        chk("tie_start", sccb_start, 1);
        chk("tie_grant0", grant, 0);
        wait_done(12, 200, "tie_ndone");
        tick;
        chk("queues_empty", exp_q.size() + fly_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
